down_counter_timer: RTL and testbench

- Loadable down-counter, the counterpart to the free-running four_bit_counter up-counter.
- Accepts a start value through a valid/ready load handshake, then decrements on count_enable.
- Flags expiry with a one-cycle terminal pulse and a held done level.
- Used as a programmable delay/interval timer by the control FSMs in the same datapath.

---
 rtl/down_counter_timer_if.sv | 24 ++
 rtl/down_counter_timer.sv | 91 +++++++++
 tb/tb_down_counter_timer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// Load handshake and status bundle for down_counter_timer.
// The master side offers load values and enables; the slave side is the timer.
interface down_counter_timer_if #(
   parameter int WIDTH = 4
) ();
   logic             load_valid;
   logic [WIDTH-1:0] load_value;
   logic             load_ready;
   logic             count_enable;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             terminal;
   logic             done;

   modport master (
      output load_valid, load_value, count_enable,
      input  load_ready, count, busy, terminal, done
   );

   modport slave (
      input  load_valid, load_value, count_enable,
      output load_ready, count, busy, terminal, done
   );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: one-shot or periodic, with a one-cycle terminal
// pulse on expiry and a held done level once a one-shot run finishes.
module down_counter_timer #(
   parameter int WIDTH       = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   down_counter_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             terminal_q, terminal_d;
   logic             done_q, done_d;
   logic             load_fire;

   assign bus.load_ready = (state_q != COUNT);
   assign load_fire      = bus.load_valid && (state_q != COUNT);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      reload_d   = reload_q;
      terminal_d = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (load_fire) begin
               count_d  = bus.load_value;
               reload_d = bus.load_value;
               // A zero load expires at once, in either mode, so it can never loop.
               if (bus.load_value != '0) begin
                  state_d = COUNT;
               end else begin
                  state_d    = DONE;
                  terminal_d = 1'b1;
               end
            end
         end
         COUNT: begin
            if (bus.count_enable) begin
               if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
               end else if (count_q == WIDTH'(1)) begin
                  count_d    = '0;
                  terminal_d = 1'b1;
                  if (!AUTO_RELOAD) state_d = DONE;
               end else begin
                  // Periodic mode spends one cycle at zero, then restarts the period.
                  count_d = reload_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == COUNT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         reload_q   <= '0;
         busy_q     <= 1'b0;
         terminal_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         reload_q   <= reload_d;
         busy_q     <= busy_d;
         terminal_q <= terminal_d;
         done_q     <= done_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.busy     = busy_q;
   assign bus.terminal = terminal_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench: one-shot and periodic timers share stimulus; each has its own
// reference model and expected-output queue, drained by a negedge monitor.
module tb_down_counter_timer;
   localparam int W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   down_counter_timer_if #(.WIDTH(W)) bus0 ();
   down_counter_timer_if #(.WIDTH(W)) bus1 ();

   down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   typedef struct packed {
      logic [W-1:0] count;
      logic         busy;
      logic         terminal;
      logic         done;
      logic         ready;
   } obs_t;

   obs_t exp_q0[$];
   obs_t exp_q1[$];
   obs_t e0, a0, e1, a1;
   int   errors = 0;
   int   checks = 0;

   // Reference: remaining ticks, period, and whether a run is in progress / finished.
   int m_left[2];
   int m_period[2];
   bit m_running[2];
   bit m_finished[2];

   function automatic obs_t model(input int k, input bit ar, input bit r,
                                  input bit lv, input int v, input bit en);
      obs_t o;
      bit   tick;
      tick = 1'b0;
      if (!r) begin
         m_left[k] = 0; m_period[k] = 0; m_running[k] = 0; m_finished[k] = 0;
      end else if (!m_running[k]) begin
         if (lv) begin
            m_left[k]     = v;
            m_period[k]   = v;
            m_running[k]  = (v != 0);
            m_finished[k] = (v == 0);
            tick          = (v == 0);
         end
      end else if (en) begin
         if (m_left[k] == 0) begin
            m_left[k] = m_period[k];
         end else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
               tick = 1'b1;
               if (!ar) begin
                  m_running[k]  = 0;
                  m_finished[k] = 1;
               end
            end
         end
      end
      o.count    = W'(m_left[k]);
      o.busy     = m_running[k];
      o.terminal = tick;
      o.done     = m_finished[k];
      o.ready    = !m_running[k];
      return o;
   endfunction

   task automatic step(input bit r, input bit lv, input int v, input bit en);
      reset              = r;
      bus0.load_valid    = lv;
      bus1.load_valid    = lv;
      bus0.load_value    = W'(v);
      bus1.load_value    = W'(v);
      bus0.count_enable  = en;
      bus1.count_enable  = en;
      @(posedge clk);
      #1;
      exp_q0.push_back(model(0, 1'b0, r, lv, v, en));
      exp_q1.push_back(model(1, 1'b1, r, lv, v, en));
   endtask

   always @(negedge clk) begin
      if (exp_q0.size() > 0) begin
         e0 = exp_q0.pop_front();
         a0 = {bus0.count, bus0.busy, bus0.terminal, bus0.done, bus0.load_ready};
         checks++;
         if (a0 !== e0) begin
            errors++;
            $display("FAIL oneshot t=%0t got cnt=%0d busy=%b term=%b done=%b rdy=%b want cnt=%0d busy=%b term=%b done=%b rdy=%b",
                     $time, a0.count, a0.busy, a0.terminal, a0.done, a0.ready,
                     e0.count, e0.busy, e0.terminal, e0.done, e0.ready);
         end
      end
      if (exp_q1.size() > 0) begin
         e1 = exp_q1.pop_front();
         a1 = {bus1.count, bus1.busy, bus1.terminal, bus1.done, bus1.load_ready};
         checks++;
         if (a1 !== e1) begin
            errors++;
            $display("FAIL periodic t=%0t got cnt=%0d busy=%b term=%b done=%b rdy=%b want cnt=%0d busy=%b term=%b done=%b rdy=%b",
                     $time, a1.count, a1.busy, a1.terminal, a1.done, a1.ready,
                     e1.count, e1.busy, e1.terminal, e1.done, e1.ready);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus0.load_valid = 1'b0; bus1.load_valid = 1'b0;
      bus0.load_value = '0;   bus1.load_value = '0;
      bus0.count_enable = 1'b0; bus1.count_enable = 1'b0;

      // Reset, then load 5 with enable held high.
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 1, 5, 1);
      repeat (8) step(1, 0, 0, 1);

      // Enable gaps: load 3, enables 1,0,0,1,1.
      step(0, 0, 0, 0);
      step(1, 1, 3, 0);
      step(1, 0, 0, 1); step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(1, 0, 0, 1); step(1, 0, 0, 1);
      step(1, 0, 0, 0); step(1, 0, 0, 0);

      // Load of 9 offered throughout a count of 4; taken only once ready.
      step(0, 0, 0, 0);
      step(1, 1, 4, 1);
      repeat (6) step(1, 1, 9, 1);
      step(1, 0, 0, 1);

      // Zero load, both modes, including a second zero load from DONE.
      step(0, 0, 0, 0);
      step(1, 1, 0, 1);
      repeat (3) step(1, 0, 0, 1);
      step(1, 1, 0, 1);
      step(1, 0, 0, 1);

      // Periodic reload of 2 under continuous enable.
      step(0, 0, 0, 0);
      step(1, 1, 2, 1);
      repeat (10) step(1, 0, 0, 1);

      // Maximum load, then reset mid-count, then a short load of 2.
      step(0, 0, 0, 0);
      step(1, 1, 15, 1);
      repeat (6) step(1, 0, 0, 1);
      step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      step(1, 1, 2, 1);
      repeat (4) step(1, 0, 0, 1);

      // Randomized traffic with occasional resets and frequent short loads.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) != 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0));
      end

      step(1, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d/%0d pending want 0/0", exp_q0.size(), exp_q1.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
